// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and resolved-branch update signals of the branch target buffer.
// The slave modport is the BTB itself; the master is the fetch/resolve side driving it.
interface btb_predictor_if #(
    parameter int ENTRIES  = 8,
    parameter int TAG_W    = 21,
    parameter int TARGET_W = 32
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [TAG_W-1:0]    lookup_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [TARGET_W-1:0] pred_target;
    logic [IDX_W-1:0]    pred_idx;

    logic                upd_valid;
    logic [TAG_W-1:0]    upd_pc;
    logic                upd_taken;
    logic [TARGET_W-1:0] upd_target;
    logic                flush;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  pred_hit, pred_taken, pred_target, pred_idx
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output pred_hit, pred_taken, pred_target, pred_idx
    );
endinterface

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer: same-cycle lookup, saturating direction counters,
// registered update with invalid-first / round-robin replacement and flush.
module btb_predictor #(
    parameter int                  ENTRIES     = 8,
    parameter int                  TAG_W       = 21,
    parameter int                  TARGET_W    = 32,
    parameter int                  CNT_W       = 2,
    parameter logic [TARGET_W-1:0] FALLTHROUGH = TARGET_W'(4)
) (
    input  logic             clk,
    input  logic             rst,
    btb_predictor_if.slave   bus
);
    localparam int             IDX_W      = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(1) << (CNT_W - 1);

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [TARGET_W-1:0] r_target [ENTRIES];
    logic [CNT_W-1:0]    r_cnt    [ENTRIES];
    logic [IDX_W-1:0]    r_rr_ptr;

    logic             w_lk_hit;
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_lk_taken;
    logic             w_up_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic             w_free_any;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_victim;

    // Priority encoders for lookup match, update match and first free slot; the
    // "already found" guard makes the lowest index win.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_lk_hit   = 1'b0;
        w_lk_idx   = '0;
        w_up_hit   = 1'b0;
        w_up_idx   = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!w_lk_hit && r_valid[i] && (r_tag[i] == bus.lookup_pc)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = IDX_W'(i);
            end
            if (!w_up_hit && r_valid[i] && (r_tag[i] == bus.upd_pc)) begin
                w_up_hit = 1'b1;
                w_up_idx = IDX_W'(i);
            end
            if (!w_free_any && !r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_lk_taken      = w_lk_hit & r_cnt[w_lk_idx][CNT_W-1];
    assign w_victim        = w_free_any ? w_free_idx : r_rr_ptr;

    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_taken;
    assign bus.pred_target = w_lk_taken ? r_target[w_lk_idx] : FALLTHROUGH;
    assign bus.pred_idx    = w_lk_idx;

    // NOTE: the entry arrays are reset on purpose so a post-reset lookup and a
    // reused entry never expose stale tag/target/counter contents.
    // NOTE: state is written with non-blocking assignments so every read in this
    // block and in the lookup logic sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
        end else if (bus.upd_valid) begin
            if (w_up_hit) begin
                if (bus.upd_taken) begin
                    if (r_cnt[w_up_idx] != CNT_MAX)
                        r_cnt[w_up_idx] <= r_cnt[w_up_idx] + CNT_W'(1);
                    r_target[w_up_idx] <= bus.upd_target;
                end else if (r_cnt[w_up_idx] != '0) begin
                    r_cnt[w_up_idx] <= r_cnt[w_up_idx] - CNT_W'(1);
                end
            end else if (bus.upd_taken) begin
                r_valid[w_victim]  <= 1'b1;
                r_tag[w_victim]    <= bus.upd_pc;
                r_target[w_victim] <= bus.upd_target;
                r_cnt[w_victim]    <= WEAK_TAKEN;
                // Round-robin only advances when a live entry is evicted.
                if (!w_free_any)
                    r_rr_ptr <= r_rr_ptr + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Table-driven bench for btb_predictor: each row drives one lookup plus an optional
// update/flush; the lookup expectation goes through a scoreboard queue before compare.
module tb_btb_predictor;
    localparam int ENTRIES  = 8;
    localparam int TAG_W    = 21;
    localparam int TARGET_W = 32;
    localparam int IDX_W    = 3;

    localparam logic                Y    = 1'b1;
    localparam logic                N    = 1'b0;
    localparam logic [TARGET_W-1:0] FT   = 32'd4;
    localparam logic [TARGET_W-1:0] T0   = 32'd0;
    localparam logic [TAG_W-1:0]    PC_A = 21'h00100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_predictor_if #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .TARGET_W(TARGET_W)) bus ();

    btb_predictor #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .TARGET_W(TARGET_W), .CNT_W(2), .FALLTHROUGH(FT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string               name;
        logic                uv;
        logic [TAG_W-1:0]    upc;
        logic                ut;
        logic [TARGET_W-1:0] utgt;
        logic                fl;
        logic [TAG_W-1:0]    lpc;
        logic                eh;
        logic                et;
        logic [TARGET_W-1:0] etgt;
        logic [IDX_W-1:0]    eidx;
    } vec_t;

    typedef struct {
        string               name;
        logic                hit;
        logic                taken;
        logic [TARGET_W-1:0] target;
        logic [IDX_W-1:0]    idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string name, logic uv, logic [TAG_W-1:0] upc, logic ut,
                                logic [TARGET_W-1:0] utgt, logic fl, logic [TAG_W-1:0] lpc,
                                logic eh, logic et, logic [TARGET_W-1:0] etgt,
                                logic [IDX_W-1:0] eidx);
        vec_t v;
        v.name = name; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fl = fl;
        v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt; v.eidx = eidx;
        vecs.push_back(v);
    endfunction

    function automatic void expect_out(string name, logic eh, logic et,
                                       logic [TARGET_W-1:0] etgt, logic [IDX_W-1:0] eidx);
        exp_t e;
        e.name = name; e.hit = eh; e.taken = et; e.target = etgt; e.idx = eidx;
        sb.push_back(e);
    endfunction

    task automatic check();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
        end else begin
            e = sb.pop_front();
            if (bus.pred_hit !== e.hit || bus.pred_taken !== e.taken ||
                bus.pred_target !== e.target || bus.pred_idx !== e.idx) begin
                n_bad++;
                $display("FAIL %s: got hit=%0b taken=%0b target=%h idx=%0d, required hit=%0b taken=%0b target=%h idx=%0d",
                         e.name, bus.pred_hit, bus.pred_taken, bus.pred_target, bus.pred_idx,
                         e.hit, e.taken, e.target, e.idx);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.upd_valid  = v.uv;
        bus.upd_pc     = v.upc;
        bus.upd_taken  = v.ut;
        bus.upd_target = v.utgt;
        bus.flush      = v.fl;
        bus.lookup_pc  = v.lpc;
        expect_out(v.name, v.eh, v.et, v.etgt, v.eidx);
        #1 check();
    endtask

    initial begin
        // Counter history for PC_A is tracked in the row names (cnt value before each lookup).
        add("post_reset",       N, PC_A, N, T0,            N, PC_A, N, N, FT,            3'd0);
        add("alloc_same_cycle", Y, PC_A, Y, 32'h8000_0040, N, PC_A, N, N, FT,            3'd0);
        add("hit_cnt10",        Y, PC_A, N, T0,            N, PC_A, Y, Y, 32'h8000_0040, 3'd0);
        add("hit_cnt01",        Y, PC_A, N, T0,            N, PC_A, Y, N, FT,            3'd0);
        add("hit_cnt00",        Y, PC_A, Y, 32'h8000_0080, N, PC_A, Y, N, FT,            3'd0);
        add("hit_cnt01_up",     Y, PC_A, Y, 32'h8000_0080, N, PC_A, Y, N, FT,            3'd0);
        add("hit_cnt10_up",     Y, PC_A, Y, 32'h8000_00C0, N, PC_A, Y, Y, 32'h8000_0080, 3'd0);
        add("hit_cnt11",        Y, PC_A, Y, 32'h8000_00C0, N, PC_A, Y, Y, 32'h8000_00C0, 3'd0);
        add("cnt_sat_11",       Y, PC_A, N, T0,            N, PC_A, Y, Y, 32'h8000_00C0, 3'd0);
        add("hit_cnt10_down",   Y, PC_A, N, T0,            N, PC_A, Y, Y, 32'h8000_00C0, 3'd0);
        add("hit_cnt01_down",   Y, PC_A, N, T0,            N, PC_A, Y, N, FT,            3'd0);
        add("hit_cnt00_floor",  Y, PC_A, N, T0,            N, PC_A, Y, N, FT,            3'd0);
        add("cnt_floor_00",     N, PC_A, N, T0,            N, PC_A, Y, N, FT,            3'd0);
        add("nt_miss_update",   Y, 21'h333, N, 32'h3333,   N, 21'h333, N, N, FT,         3'd0);
        add("nt_miss_no_alloc", N, PC_A, N, T0,            N, 21'h333, N, N, FT,         3'd0);
        add("flush_same_cycle", Y, 21'h55, Y, 32'h5555,    Y, PC_A, Y, N, FT,            3'd0);
        add("flush_clears_a",   N, PC_A, N, T0,            N, PC_A, N, N, FT,            3'd0);
        add("flush_drops_55",   N, PC_A, N, T0,            N, 21'h55, N, N, FT,          3'd0);
        for (int k = 1; k <= 8; k++)
            add($sformatf("fill_%0d", k), Y, TAG_W'(k), Y, TARGET_W'(32'h1000 + k * 16), N,
                TAG_W'(k), N, N, FT, 3'd0);
        add("fill_last_idx7",   Y, 21'd9,  Y, 32'h9000, N, 21'd8,  Y, Y, 32'h1080, 3'd7);
        add("rr_tag9_idx0",     Y, 21'd10, Y, 32'hA000, N, 21'd9,  Y, Y, 32'h9000, 3'd0);
        add("rr_tag10_idx1",    N, PC_A,   N, T0,       N, 21'd10, Y, Y, 32'hA000, 3'd1);
        add("evicted_tag1",     N, PC_A,   N, T0,       N, 21'd1,  N, N, FT,       3'd0);
        add("evicted_tag2",     N, PC_A,   N, T0,       N, 21'd2,  N, N, FT,       3'd0);
        add("kept_tag3",        Y, 21'd11, Y, 32'hB000, N, 21'd3,  Y, Y, 32'h1030, 3'd2);
        add("kept_tag4",        N, PC_A,   N, T0,       N, 21'd4,  Y, Y, 32'h1040, 3'd3);
        add("rr_tag11_idx2",    N, PC_A,   N, T0,       N, 21'd11, Y, Y, 32'hB000, 3'd2);
        add("evicted_tag3",     N, PC_A,   N, T0,       N, 21'd3,  N, N, FT,       3'd0);
        add("same_cycle_20",    Y, 21'h20, N, T0,       N, 21'h20, N, N, FT,       3'd0);
        add("upd_20_taken",     Y, 21'h20, Y, 32'h2020, N, 21'h20, N, N, FT,       3'd0);
        add("lookup_20_next",   N, PC_A,   N, T0,       N, 21'h20, Y, Y, 32'h2020, 3'd3);
    end

    initial begin
        vec_t v;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.flush      = 1'b0;
        bus.lookup_pc  = PC_A;
        rst = 1'b1;

        // Outputs while reset is held, before any clock edge.
        #2;
        expect_out("during_reset", N, N, FT, 3'd0);
        check();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v);
        end

        // Asynchronous reset mid-operation: tag 11 is live at idx2 before reset.
        @(negedge clk);
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.lookup_pc = 21'd11;
        expect_out("pre_async_reset", Y, Y, 32'hB000, 3'd2);
        #1 check();
        #1 rst = 1'b1;
        expect_out("async_reset_clear", N, N, FT, 3'd0);
        #1 check();
        @(negedge clk);
        rst = 1'b0;

        v.name = "post_reset_alloc"; v.uv = Y; v.upc = 21'h77; v.ut = Y; v.utgt = 32'h7700;
        v.fl = N; v.lpc = 21'd11; v.eh = N; v.et = N; v.etgt = FT; v.eidx = 3'd0;
        apply(v);
        v.name = "post_reset_idx0"; v.uv = N; v.lpc = 21'h77; v.eh = Y; v.et = Y;
        v.etgt = 32'h7700; v.eidx = 3'd0;
        apply(v);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
